// File: rtl/lock_keypad_sender.sv
// rtl/lock_keypad_sender.sv - keypad front end: sync, debounce, digit FIFO, strobe sender
module lock_keypad_sender #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [3:0] digit_raw,
  output logic       enter,
  output logic [3:0] digit,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP_CYCLES);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic          btn_s1, btn_s2;
  logic [3:0]    dig_s1, dig_s2;
  logic          db;
  logic [15:0]   cnt;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  state_t        state;
  logic [7:0]    gap_cnt;
  logic          db_rise, push, pop, full, empty;

  // Extra pointer bit separates full from empty after wrap-around.
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH);
  // db is about to go 0->1 on this edge: that is the capture moment.
  assign db_rise    = !db && btn_s2 && (cnt == DB_LAST);
  assign pop        = (state == IDLE) && !empty;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign push       = db_rise && (!full || pop);
  assign busy       = !empty || (state != IDLE);
  assign fifo_count = 3'(count);

  // Two-flop synchronizer for the button and the keypad digit together.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      dig_s1 <= 4'd0;
      dig_s2 <= 4'd0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      dig_s1 <= digit_raw;
      dig_s2 <= dig_s1;
    end
  end

  // Debouncer: level follows s2 only after it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      db  <= 1'b0;
      cnt <= 16'd0;
    end else if (btn_s2 == db) begin
      cnt <= 16'd0;
    end else if (cnt == DB_LAST) begin
      db  <= btn_s2;
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dig_s2;
  end

  // FIFO pointers and sticky overflow on a dropped press.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (db_rise && !push) overflow <= 1'b1;
    end
  end

  // Sender FSM: one-cycle strobe, then GAP_CYCLES of GAP and one IDLE before the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      enter   <= 1'b0;
      digit   <= 4'd0;
      gap_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            digit <= mem[rd_ptr[AW-1:0]];
            enter <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          enter   <= 1'b0;
          gap_cnt <= GAP_LOAD;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt <= 8'd1) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: begin
          enter <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
